// File: rtl/fft_out_reorder.sv
// Output reorder buffer for the 64-point FFT core: bit-reversed pairs in, natural-order bins out.
// Ping-pong banks let one frame stream out while the next is written; overrun frames are dropped.
module fft_out_reorder #(
  parameter int BW     = 16,
  parameter int N_LOG2 = 6
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  input  logic [BW-1:0]     in_real0,
  input  logic [BW-1:0]     in_imag0,
  input  logic [BW-1:0]     in_real1,
  input  logic [BW-1:0]     in_imag1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BW-1:0]     out_real,
  output logic [BW-1:0]     out_imag,
  output logic [N_LOG2-1:0] out_index,
  output logic              out_last,
  output logic              overflow
);

  localparam int N  = 1 << N_LOG2;
  localparam int HW = N_LOG2 - 1;
  localparam logic [HW-1:0]     CNT_ONE = HW'(1);
  localparam logic [N_LOG2-1:0] IDX_ONE = N_LOG2'(1);

  typedef enum logic {IDLE, STREAM} state_t;

  function automatic logic [HW-1:0] bitrev(input logic [HW-1:0] k);
    logic [HW-1:0] r;
    for (int i = 0; i < HW; i++) r[i] = k[HW-1-i];
    return r;
  endfunction

  // Lane0 bins always have address MSB 0 and lane1 bins MSB 1, so each lane owns a sub-bank.
  logic [2*BW-1:0] mem_lo_q [N];
  logic [2*BW-1:0] mem_hi_q [N];

  state_t              state_q, state_d;
  logic                rsel_q, rsel_d;
  logic [N_LOG2-1:0]   rd_idx_q, rd_idx_d;
  logic [BW-1:0]       out_real_q, out_real_d;
  logic [BW-1:0]       out_imag_q, out_imag_d;
  logic                free_rd, load;
  logic [N_LOG2-1:0]   rd_addr;
  logic [2*BW-1:0]     rd_word;

  logic [HW-1:0]       wr_cnt_q, wr_cnt_d;
  logic                wsel_q, wsel_d;
  logic                drop_q, drop_d;
  logic [1:0]          bank_full_q, bank_full_d;
  logic                overflow_q, overflow_d;
  logic                full_eff, frame_start, wr_en, frame_done;

  always_comb begin
    state_d  = state_q;
    rsel_d   = rsel_q;
    rd_idx_d = rd_idx_q;
    free_rd  = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bank_full_q[rsel_q]) begin
          state_d  = STREAM;
          rd_idx_d = '0;
          load     = 1'b1;
        end
      end
      STREAM: begin
        if (out_ready) begin
          load = 1'b1;
          if (&rd_idx_q) begin
            free_rd  = 1'b1;
            rsel_d   = ~rsel_q;
            rd_idx_d = '0;
            if (!bank_full_q[!rsel_q]) begin
              state_d = IDLE;
              load    = 1'b0;
            end
          end else begin
            rd_idx_d = rd_idx_q + IDX_ONE;
          end
        end
      end
      default: ;
    endcase
  end

  assign rd_addr    = {rsel_d, rd_idx_d[HW-1:0]};
  assign rd_word    = rd_idx_d[N_LOG2-1] ? mem_hi_q[rd_addr] : mem_lo_q[rd_addr];
  assign out_real_d = load ? rd_word[2*BW-1:BW] : out_real_q;
  assign out_imag_d = load ? rd_word[BW-1:0]    : out_imag_q;

  // A bank being freed this cycle already counts as free for a frame starting this cycle.
  always_comb begin
    full_eff    = bank_full_q[wsel_q] & ~(free_rd & (rsel_q == wsel_q));
    frame_start = in_valid & (wr_cnt_q == '0);
    wr_en       = in_valid & (frame_start ? ~full_eff : ~drop_q);
    frame_done  = wr_en & (&wr_cnt_q);
    drop_d      = frame_start ? full_eff : drop_q;
    overflow_d  = overflow_q | (frame_start & full_eff);
    wr_cnt_d    = in_valid ? wr_cnt_q + CNT_ONE : wr_cnt_q;
    wsel_d      = frame_done ? ~wsel_q : wsel_q;
    bank_full_d = bank_full_q;
    if (free_rd)    bank_full_d[rsel_q] = 1'b0;
    if (frame_done) bank_full_d[wsel_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      rsel_q      <= 1'b0;
      rd_idx_q    <= '0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      wr_cnt_q    <= '0;
      wsel_q      <= 1'b0;
      drop_q      <= 1'b0;
      bank_full_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsel_q      <= rsel_d;
      rd_idx_q    <= rd_idx_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
      wr_cnt_q    <= wr_cnt_d;
      wsel_q      <= wsel_d;
      drop_q      <= drop_d;
      bank_full_q <= bank_full_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_lo_q[{wsel_q, bitrev(wr_cnt_q)}] <= {in_real0, in_imag0};
      mem_hi_q[{wsel_q, bitrev(wr_cnt_q)}] <= {in_real1, in_imag1};
    end
  end

  assign out_valid = (state_q == STREAM);
  assign out_last  = (state_q == STREAM) & (&rd_idx_q);
  assign out_index = rd_idx_q;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;
  assign overflow  = overflow_q;

endmodule
